// File: rtl/gray_code_counter_if.sv
// Handshake and data bundle for gray_code_counter: step/load requests in,
// registered Gray/binary code out under a valid/ready handshake.
interface gray_code_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             wrap;

    // Producer of requests / consumer of codes
    modport master (
        output en, up, load, load_bin, out_ready,
        input  out_valid, gray, bin, wrap
    );

    // The counter itself
    modport slave (
        input  en, up, load, load_bin, out_ready,
        output out_valid, gray, bin, wrap
    );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down binary counter with Gray encoding and a one-entry registered
// output stage. A new code is taken whenever the stage is empty or the
// consumer is accepting the current one; a stalled code is never overwritten.
module gray_code_counter #(
    parameter int WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    gray_code_counter_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [WIDTH-1:0] w_bin_next;
    logic             w_wrap_next;
    logic             w_accept;

    // Next-state and next-code selection: load beats en, stall holds everything
    always_comb begin
        w_state_next = r_state;
        w_bin_next   = r_bin;
        w_wrap_next  = r_wrap;
        w_accept     = (r_state == IDLE) || bus.out_ready;
        if (w_accept) begin
            if (bus.load) begin
                w_bin_next   = bus.load_bin;
                w_wrap_next  = 1'b0;
                w_state_next = VALID;
            end else if (bus.en) begin
                if (bus.up) begin
                    w_bin_next  = r_bin + ONE;
                    w_wrap_next = (r_bin == '1);
                end else begin
                    w_bin_next  = r_bin - ONE;
                    w_wrap_next = (r_bin == '0);
                end
                w_state_next = VALID;
            end else if (r_state == VALID) begin
                w_state_next = IDLE;
            end
        end
    end

    // State and output registers; gray is registered alongside bin so both
    // change on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_gray  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bin   <= w_bin_next;
            r_gray  <= w_bin_next ^ (w_bin_next >> 1);
            r_wrap  <= w_wrap_next;
        end
    end

    assign bus.out_valid = (r_state == VALID);
    assign bus.bin       = r_bin;
    assign bus.gray      = r_gray;
    assign bus.wrap      = r_wrap;
endmodule
